quad_step_decoder: RTL and testbench



---
 rtl/quad_pkg.sv | 31 +++
 rtl/quad_input_filter.sv | 61 ++++++
 rtl/quad_step_decoder.sv | 130 +++++++++++++
 tb/tb_quad_step_decoder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder.
package quad_pkg;

  typedef enum logic [1:0] {
    INIT0 = 2'd0,
    INIT1 = 2'd1,
    RUN   = 2'd2
  } quad_state_e;

  // Direction encoding shared with the counter's inc_dec input
  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  // Legal range of the glitch filter length
  localparam int unsigned FILT_LEN_MIN = 1;
  localparam int unsigned FILT_LEN_MAX = 15;
  localparam int unsigned FILT_CNT_W   = 4;

  // Position of an {a,b} phase pair along the forward Gray sequence 00,01,11,10
  function automatic logic [1:0] phase_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a stability filter for one encoder phase.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic din,
  input  logic load,
  output logic sync_next,
  output logic level
);

  localparam logic [FILT_CNT_W-1:0] FILT_LEN_C = FILT_CNT_W'(FILT_LEN);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  lvl_q, lvl_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;
  logic [FILT_CNT_W-1:0] cnt_inc;

  // Synchronize, then accept a new level only after FILT_LEN differing samples
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    cnt_inc = cnt_q + FILT_CNT_W'(1);
    if (load) begin
      // sync1_q is what the second stage captures on this edge, so the
      // filtered level and the sync output agree right after loading
      lvl_d = sync1_q;
    end else if (sync2_q != lvl_q) begin
      if (cnt_inc == FILT_LEN_C) begin
        lvl_d = sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Synchronizer, filter counter and filtered level registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_next = sync1_q;
  assign level     = lvl_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: step strobe + direction for the up/down counter,
// local preloadable position register and sticky illegal-transition flag.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILT_LEN = 3,
  parameter int unsigned POS_W    = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             qa,
  input  logic             qb,
  input  logic             clr,
  input  logic             preload_en,
  input  logic [POS_W-1:0] preload_value,
  input  logic             err_clr,
  output logic             step_en,
  output logic             step_dir,
  output logic [POS_W-1:0] position,
  output logic             phase_err
);

  quad_state_e      state_q, state_d;
  logic [1:0]       prev_ab_q, prev_ab_d;
  logic             step_en_q, step_en_d;
  logic             step_dir_q, step_dir_d;
  logic [POS_W-1:0] position_q, position_d;
  logic             phase_err_q, phase_err_d;

  logic             a_lvl, b_lvl, a_next, b_next;
  logic             filt_load;
  logic [1:0]       cur_ab;
  logic [1:0]       delta;
  logic             run, fwd, rev, illegal;

  assign filt_load = (state_q == INIT1);

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .din       (qa),
    .load      (filt_load),
    .sync_next (a_next),
    .level     (a_lvl)
  );

  quad_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .din       (qb),
    .load      (filt_load),
    .sync_next (b_next),
    .level     (b_lvl)
  );

  assign cur_ab = {a_lvl, b_lvl};

  // Start-up sequencing: two settle cycles, then decode until reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT0:   state_d = INIT1;
      INIT1:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Classify the filtered phase change and compute next outputs/position
  always_comb begin
    run     = (state_q == RUN);
    delta   = phase_idx(cur_ab) - phase_idx(prev_ab_q);
    fwd     = run && (delta == 2'd1);
    rev     = run && (delta == 2'd3);
    illegal = run && (delta == 2'd2);

    // Previous state is seeded with the same value the filters load
    prev_ab_d = filt_load ? {a_next, b_next} : cur_ab;

    step_en_d  = fwd | rev;
    step_dir_d = step_dir_q;
    if (fwd) begin
      step_dir_d = DIR_INC;
    end else if (rev) begin
      step_dir_d = DIR_DEC;
    end

    phase_err_d = phase_err_q;
    if (illegal) begin
      phase_err_d = 1'b1;
    end else if (err_clr) begin
      phase_err_d = 1'b0;
    end

    position_d = position_q;
    if (clr) begin
      position_d = '0;
    end else if (preload_en) begin
      position_d = preload_value;
    end else if (fwd) begin
      position_d = position_q + POS_W'(1);
    end else if (rev) begin
      position_d = position_q - POS_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= INIT0;
      prev_ab_q   <= '0;
      step_en_q   <= 1'b0;
      step_dir_q  <= 1'b0;
      position_q  <= '0;
      phase_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_ab_q   <= prev_ab_d;
      step_en_q   <= step_en_d;
      step_dir_q  <= step_dir_d;
      position_q  <= position_d;
      phase_err_q <= phase_err_d;
    end
  end

  assign step_en   = step_en_q;
  assign step_dir  = step_dir_q;
  assign position  = position_q;
  assign phase_err = phase_err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed + randomized bench for quad_step_decoder with a behavioural model.
module tb_quad_step_decoder;

  localparam int unsigned F  = 3;
  localparam int unsigned PW = 8;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          qa, qb;
  logic          clr, preload_en, err_clr;
  logic [PW-1:0] preload_value;
  logic          step_en, step_dir;
  logic [PW-1:0] position;
  logic          phase_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [1:0]  m_ab;
  int unsigned m_pos;
  logic        m_dir;
  logic        m_err;

  quad_step_decoder #(.FILT_LEN(F), .POS_W(PW)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .qa            (qa),
    .qb            (qb),
    .clr           (clr),
    .preload_en    (preload_en),
    .preload_value (preload_value),
    .err_clr       (err_clr),
    .step_en       (step_en),
    .step_dir      (step_dir),
    .position      (position),
    .phase_err     (phase_err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int unsigned idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Apply one accepted phase change (or none) plus controls to the model
  task automatic model_apply(input logic [1:0] nab, input logic c_clr, input logic c_pre,
                             input logic c_ecl, input logic [PW-1:0] pv, output logic stepped);
    int unsigned d;
    d = (gidx(nab) + 4 - gidx(m_ab)) % 4;
    stepped = (d == 1) || (d == 3);
    if (d == 1) m_dir = 1'b0;
    else if (d == 3) m_dir = 1'b1;
    if (d == 2) m_err = 1'b1;
    else if (c_ecl) m_err = 1'b0;
    if (c_clr) m_pos = 0;
    else if (c_pre) m_pos = pv;
    else if (d == 1) m_pos = (m_pos + 1) % 256;
    else if (d == 3) m_pos = (m_pos + 255) % 256;
    m_ab = nab;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pos"}, position, m_pos);
    chk({tag, "_dir"}, step_dir, m_dir);
    chk({tag, "_err"}, phase_err, m_err);
  endtask

  // Drive a new level and hold it; the strobe must land exactly F+3 edges later
  task automatic move(input logic [1:0] nab, input int unsigned hold, input logic c_clr,
                      input logic c_pre, input logic c_ecl, input logic [PW-1:0] pv);
    logic stepped;
    qa = nab[1];
    qb = nab[0];
    for (int unsigned k = 1; k <= hold; k++) begin
      if (k == F + 3) begin
        clr = c_clr; preload_en = c_pre; err_clr = c_ecl; preload_value = pv;
      end
      @(posedge aclk); #1;
      if (k == F + 3) begin
        clr = 1'b0; preload_en = 1'b0; err_clr = 1'b0;
        model_apply(nab, c_clr, c_pre, c_ecl, pv, stepped);
        chk("move_step", step_en, stepped);
        check_state("move");
      end else begin
        chk("move_idle", step_en, 1'b0);
      end
    end
  endtask

  // Pulse qa for n cycles; shorter than F must be invisible
  task automatic pulse_a(input int unsigned n);
    logic [1:0] base, alt;
    logic s;
    base = m_ab;
    alt  = base ^ 2'b10;
    qa = alt[1];
    for (int unsigned k = 1; k <= n + F + 8; k++) begin
      if (k == n + 1) qa = base[1];
      @(posedge aclk); #1;
      if (n >= F && k == F + 3) begin
        model_apply(alt, 1'b0, 1'b0, 1'b0, '0, s);
        chk("pulse_step1", step_en, s);
        check_state("pulse1");
      end else if (n >= F && k == n + F + 3) begin
        model_apply(base, 1'b0, 1'b0, 1'b0, '0, s);
        chk("pulse_step2", step_en, s);
        check_state("pulse2");
      end else begin
        chk("pulse_idle", step_en, 1'b0);
      end
    end
    check_state("pulse_end");
  endtask

  // One idle cycle with control inputs applied
  task automatic ctl(input logic c_clr, input logic c_pre, input logic c_ecl,
                     input logic [PW-1:0] pv);
    logic s;
    clr = c_clr; preload_en = c_pre; err_clr = c_ecl; preload_value = pv;
    @(posedge aclk); #1;
    clr = 1'b0; preload_en = 1'b0; err_clr = 1'b0;
    model_apply(m_ab, c_clr, c_pre, c_ecl, pv, s);
    chk("ctl_step", step_en, s);
    check_state("ctl");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_step_en"}, step_en, 1'b0);
    chk({tag, "_dir"}, step_dir, 1'b0);
    chk({tag, "_pos"}, position, 32'd0);
    chk({tag, "_err"}, phase_err, 1'b0);
  endtask

  initial begin
    logic [1:0] nab;
    int unsigned r;

    aresetn = 1'b0; qa = 1'b0; qb = 1'b0;
    clr = 1'b0; preload_en = 1'b0; err_clr = 1'b0; preload_value = '0;
    m_ab = 2'b00; m_pos = 0; m_dir = 1'b0; m_err = 1'b0;

    #22;
    check_reset_outputs("reset");
    @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk); #1;
      chk("init_step_en", step_en, 1'b0);
    end
    check_state("init");

    // Forward Gray sequence: four increments
    move(2'b01, 10, 1'b0, 1'b0, 1'b0, '0);
    move(2'b11, 10, 1'b0, 1'b0, 1'b0, '0);
    move(2'b10, 10, 1'b0, 1'b0, 1'b0, '0);
    move(2'b00, 10, 1'b0, 1'b0, 1'b0, '0);

    // Preload then reverse through zero
    ctl(1'b0, 1'b1, 1'b0, 8'h02);
    move(2'b10, 10, 1'b0, 1'b0, 1'b0, '0);
    move(2'b11, 10, 1'b0, 1'b0, 1'b0, '0);
    move(2'b01, 10, 1'b0, 1'b0, 1'b0, '0);
    move(2'b00, 10, 1'b0, 1'b0, 1'b0, '0);

    // Glitch rejection and minimum accepted pulse
    pulse_a(2);
    pulse_a(3);

    // Illegal jumps and sticky error behaviour
    move(2'b11, 10, 1'b0, 1'b0, 1'b0, '0);
    ctl(1'b0, 1'b0, 1'b1, '0);
    move(2'b00, 10, 1'b0, 1'b0, 1'b1, '0);
    ctl(1'b0, 1'b0, 1'b1, '0);

    // Reset in the middle of a transition toward 11
    move(2'b01, 10, 1'b0, 1'b0, 1'b0, '0);
    qa = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge aclk); #1;
      chk("pre_rst_idle", step_en, 1'b0);
    end
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    m_ab = 2'b11; m_pos = 0; m_dir = 1'b0; m_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge aclk); #1;
      chk("absorb_step_en", step_en, 1'b0);
      chk("absorb_err", phase_err, 1'b0);
    end
    check_state("absorb");
    move(2'b10, 10, 1'b0, 1'b0, 1'b0, '0);

    // clr beats preload beats step, strobe still emitted
    move(2'b00, 10, 1'b1, 1'b1, 1'b0, 8'h55);

    // Randomized legal walk with occasional preloads and pulses
    for (int i = 0; i < 40; i++) begin
      r = $urandom;
      if (r % 5 == 0) ctl(1'b0, 1'b1, 1'b0, PW'($urandom));
      if (r % 7 == 0) begin
        pulse_a($urandom_range(1, 5));
      end else begin
        nab = ab_of(gidx(m_ab) + (($urandom_range(0, 1) == 1) ? 1 : 3));
        move(nab, $urandom_range(F + 4, F + 10), 1'b0, 1'b0, 1'b0, '0);
      end
    end
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
